// File: rtl/cpu_pkg.sv
// Shared decode-stage types: register address constants, the EX/MEM history
// entry layout and the forward-select encodings used by the operand muxes.
package cpu_pkg;

   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic              v;
      logic              wr;
      logic              ld;
      logic [ADDR_W-1:0] rd;
   } hist_entry_t;

   localparam int HIST_W = $bits(hist_entry_t);

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_EX   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   // The youngest producer (EX) wins when both stages write the same register.
   function automatic logic [1:0] fwd_select(input logic use_port,
                                             input logic hit_ex,
                                             input logic hit_mem);
      if (!use_port) return FWD_NONE;
      if (hit_ex)    return FWD_EX;
      if (hit_mem)   return FWD_MEM;
      return FWD_NONE;
   endfunction

endpackage

// File: rtl/D_FF.sv
// Plain register cell with asynchronous active-high reset to zero.
module D_FF #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/fwd_compare.sv
// Matches one history entry against one read address; XZR never matches.
module fwd_compare
   import cpu_pkg::*;
(
   input  logic [HIST_W-1:0] entry,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit
);

   hist_entry_t e;
   logic        unused_ld;

   assign e         = entry;
   assign unused_ld = e.ld;
   assign hit       = e.v & e.wr & (e.rd == addr) & (addr != ZERO_REG);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding / load-use hazard tracker. Holds the destinations of
// the instructions in EX and MEM and drives forward selects and a 1-cycle stall.
module fwd_hazard_unit
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              Valid,
   input  logic [ADDR_W-1:0] RdA,
   input  logic [ADDR_W-1:0] RdB,
   input  logic              UseA,
   input  logic              UseB,
   input  logic [ADDR_W-1:0] Rd,
   input  logic              RegWrite,
   input  logic              MemToReg,
   input  logic              Flush,
   output logic              FwdT1,
   output logic              FwdT2,
   output logic              FwdT3,
   output logic              FwdT4,
   output logic              Stall,
   output logic [15:0]       StallCount
);

   hist_entry_t ex_e;
   hist_entry_t mem_e;
   hist_entry_t new_e;
   logic        hit_ex_a;
   logic        hit_mem_a;
   logic        hit_ex_b;
   logic        hit_mem_b;
   logic        reset_hi;
   logic        live;
   logic        stall;
   logic        fwd_en;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;
   logic [15:0] stall_cnt;
   logic        unused_mem_ld;

   assign reset_hi      = ~reset;
   assign unused_mem_ld = mem_e.ld;

   fwd_compare u_cmp_ex_a  (.entry(ex_e),  .addr(RdA), .hit(hit_ex_a));
   fwd_compare u_cmp_mem_a (.entry(mem_e), .addr(RdA), .hit(hit_mem_a));
   fwd_compare u_cmp_ex_b  (.entry(ex_e),  .addr(RdB), .hit(hit_ex_b));
   fwd_compare u_cmp_mem_b (.entry(mem_e), .addr(RdB), .hit(hit_mem_b));

   // Flush outranks the load-use stall; a load already in MEM is forwarded, not stalled on.
   assign live   = reset & Valid & ~Flush;
   assign stall  = live & ex_e.ld & ((UseA & hit_ex_a) | (UseB & hit_ex_b));
   assign fwd_en = live & ~stall;

   assign sel_a = fwd_en ? fwd_select(UseA, hit_ex_a, hit_mem_a) : FWD_NONE;
   assign sel_b = fwd_en ? fwd_select(UseB, hit_ex_b, hit_mem_b) : FWD_NONE;

   assign FwdT1      = (sel_a == FWD_EX);
   assign FwdT2      = (sel_a == FWD_MEM);
   assign FwdT3      = (sel_b == FWD_EX);
   assign FwdT4      = (sel_b == FWD_MEM);
   assign Stall      = stall;
   assign StallCount = stall_cnt;

   always_comb begin
      new_e = '0;
      if (Valid && !Flush && !stall) begin
         new_e.v  = 1'b1;
         new_e.wr = RegWrite;
         new_e.ld = MemToReg;
         new_e.rd = Rd;
      end
   end

   D_FF #(.W(HIST_W)) u_ex_ff  (.clk(clk), .reset(reset_hi), .d(new_e), .q(ex_e));
   D_FF #(.W(HIST_W)) u_mem_ff (.clk(clk), .reset(reset_hi), .d(ex_e),  .q(mem_e));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: reference model feeds an expected queue, directed
// scenarios plus a random instruction stream.
module tb_fwd_hazard_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        Valid;
   logic [4:0]  RdA;
   logic [4:0]  RdB;
   logic        UseA;
   logic        UseB;
   logic [4:0]  Rd;
   logic        RegWrite;
   logic        MemToReg;
   logic        Flush;
   logic        FwdT1;
   logic        FwdT2;
   logic        FwdT3;
   logic        FwdT4;
   logic        Stall;
   logic [15:0] StallCount;

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk(clk), .reset(reset), .Valid(Valid), .RdA(RdA), .RdB(RdB),
      .UseA(UseA), .UseB(UseB), .Rd(Rd), .RegWrite(RegWrite),
      .MemToReg(MemToReg), .Flush(Flush), .FwdT1(FwdT1), .FwdT2(FwdT2),
      .FwdT3(FwdT3), .FwdT4(FwdT4), .Stall(Stall), .StallCount(StallCount)
   );

   logic [31:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   // Model of the history: index 0 = EX, 1 = MEM
   logic        m_v[2];
   logic        m_wr[2];
   logic        m_ld[2];
   logic [4:0]  m_rd[2];
   logic [15:0] m_cnt;
   logic [20:0] got;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic m_hit(input int i, input logic [4:0] x);
      return m_v[i] & m_wr[i] & (m_rd[i] == x) & (x != 5'd31);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_wr[i] = 1'b0; m_ld[i] = 1'b0; m_rd[i] = 5'd0;
      end
      m_cnt = 16'd0;
   endtask

   task automatic sample();
      got = {FwdT1, FwdT2, FwdT3, FwdT4, Stall, StallCount};
   endtask

   // One decode cycle: drive, predict, compare, then advance the model for the coming edge.
   task automatic op(input string tag, input logic v, input logic [4:0] ra, input logic ua,
                     input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                     input logic wr, input logic ld, input logic fl);
      logic hea, hma, heb, hmb, stl, fe;
      @(negedge clk);
      Valid = v; RdA = ra; UseA = ua; RdB = rb; UseB = ub;
      Rd = rd; RegWrite = wr; MemToReg = ld; Flush = fl;
      hea = m_hit(0, ra); hma = m_hit(1, ra);
      heb = m_hit(0, rb); hmb = m_hit(1, rb);
      stl = v & ~fl & m_ld[0] & ((ua & hea) | (ub & heb));
      fe  = v & ~fl & ~stl;
      exp_q.push_back({11'd0, fe & ua & hea, fe & ua & ~hea & hma,
                       fe & ub & heb, fe & ub & ~heb & hmb, stl, m_cnt});
      #1;
      sample();
      check_eq(tag, {11'd0, got}, exp_q.pop_front());
      m_v[1] = m_v[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0]; m_rd[1] = m_rd[0];
      if (stl || fl || !v) begin
         m_v[0] = 1'b0; m_wr[0] = 1'b0; m_ld[0] = 1'b0; m_rd[0] = 5'd0;
      end else begin
         m_v[0] = 1'b1; m_wr[0] = wr; m_ld[0] = ld; m_rd[0] = rd;
      end
      if (stl && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] ra,
                      input logic [4:0] rb, input logic ub);
      op(tag, 1'b1, ra, 1'b1, rb, ub, rd, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic ldur(input string tag, input logic [4:0] rd, input logic [4:0] ra);
      op(tag, 1'b1, ra, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic idle(input string tag);
      op(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0; Valid = 1'b0; RdA = '0; RdB = '0; UseA = 1'b0; UseB = 1'b0;
      Rd = '0; RegWrite = 1'b0; MemToReg = 1'b0; Flush = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      sample();
      check_eq("reset_idle", {11'd0, got}, 32'd0);
      reset = 1'b1;

      // Reset mid-stream with X3 live in the history and one stall counted
      ldur("t1_ld3", 5'd3, 5'd1);
      alu("t1_use3", 5'd4, 5'd3, 5'd2, 1'b1);
      alu("t1_use3b", 5'd4, 5'd3, 5'd2, 1'b1);
      alu("t1_add3", 5'd3, 5'd1, 5'd2, 1'b0);
      @(negedge clk);
      reset = 1'b0; Valid = 1'b1; RdA = 5'd3; UseA = 1'b1; RdB = 5'd3; UseB = 1'b1;
      #1;
      sample();
      check_eq("t1_rst_out", {11'd0, got}, 32'd0);
      model_reset();
      @(negedge clk);
      #1;
      sample();
      check_eq("t1_rst_hold", {11'd0, got}, 32'd0);
      Valid = 1'b0; reset = 1'b1;
      alu("t1_after", 5'd8, 5'd3, 5'd3, 1'b1);
      check_eq("t1_after_fwd", {27'd0, got[20:16]}, 32'd0);

      // Forward priority
      alu("t2_p", 5'd3, 5'd1, 5'd2, 1'b1);
      alu("t2_c", 5'd5, 5'd3, 5'd4, 1'b1);
      check_eq("t2_ex_a", {30'd0, got[20:19]}, 32'd2);
      alu("t2_p2", 5'd3, 5'd1, 5'd2, 1'b1);
      alu("t2_mid", 5'd9, 5'd1, 5'd2, 1'b1);
      alu("t2_c2", 5'd6, 5'd3, 5'd1, 1'b1);
      check_eq("t2_mem_a", {30'd0, got[20:19]}, 32'd1);
      alu("t2_w1", 5'd3, 5'd1, 5'd2, 1'b1);
      alu("t2_w2", 5'd3, 5'd1, 5'd2, 1'b1);
      alu("t2_c3", 5'd6, 5'd3, 5'd3, 1'b1);
      check_eq("t2_ex_wins", {28'd0, got[20:17]}, 32'hA);

      // Load-use
      ldur("t3_ld7", 5'd7, 5'd1);
      alu("t3_use", 5'd8, 5'd1, 5'd7, 1'b1);
      check_eq("t3_stall", {27'd0, got[20:16]}, 32'h01);
      alu("t3_retry", 5'd8, 5'd1, 5'd7, 1'b1);
      check_eq("t3_fwd4", {27'd0, got[20:16]}, 32'h02);
      check_eq("t3_count", {16'd0, got[15:0]}, 32'd1);

      // XZR and use gating
      alu("t4_p31", 5'd31, 5'd1, 5'd2, 1'b1);
      alu("t4_c31", 5'd9, 5'd31, 5'd31, 1'b1);
      check_eq("t4_xzr", {28'd0, got[20:17]}, 32'd0);
      alu("t4_p10", 5'd10, 5'd1, 5'd2, 1'b1);
      alu("t4_nouse", 5'd11, 5'd1, 5'd10, 1'b0);
      check_eq("t4_useb", {28'd0, got[20:17]}, 32'd0);

      // Flush versus stall
      ldur("t5_ld12", 5'd12, 5'd1);
      op("t5_flush", 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
      check_eq("t5_flush_out", {27'd0, got[20:16]}, 32'd0);
      alu("t5_next", 5'd13, 5'd12, 5'd2, 1'b1);
      check_eq("t5_fwd2", {27'd0, got[20:16]}, 32'h08);

      // Counter saturation
      idle("t6_idle");
      force dut.stall_cnt = 16'hFFFE;
      #1;
      release dut.stall_cnt;
      m_cnt = 16'hFFFE;
      for (int k = 0; k < 3; k++) begin
         ldur("t6_ld", 5'd7, 5'd1);
         alu("t6_use", 5'd8, 5'd7, 5'd2, 1'b1);
         alu("t6_retry", 5'd8, 5'd7, 5'd2, 1'b1);
      end
      check_eq("t6_sat", {16'd0, got[15:0]}, 32'h0000FFFF);

      // Random instruction stream
      for (int n = 0; n < 300; n++) begin
         logic [4:0] a, b, d;
         logic       ld;
         a  = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(1, 4));
         b  = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(1, 4));
         d  = ($urandom_range(0, 5) == 5) ? 5'd31 : 5'($urandom_range(1, 4));
         ld = ($urandom_range(0, 2) == 0);
         op("rand", $urandom_range(0, 7) != 0, a, 1'($urandom_range(0, 1)),
            b, 1'($urandom_range(0, 1)), d, ld | ($urandom_range(0, 3) != 0),
            ld, $urandom_range(0, 9) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
